mpu_thread_fetch_sched: RTL
===========================

// Module: mpu_thread_fetch_sched
// PURPOSE
// - Schedules instruction fetch out of the MPU thread instruction memory.
// - Queues thread-ready notifications from the thread memory: thread ID, base address, length.
// - Per thread, in FIFO order: issues one load address per cycle to the memory's load port
//   and counts returned instruction beats; dispatch stall is honoured.
// - Signals start/end of each thread to the dispatch unit.
// PARAMETERS
// - NUM_PEND   4   depth of pending-thread queue (power of 2, >=2)
// - WIDTH_ADDR 10  instruction address / length width
// - WIDTH_ID   8   thread-ID width
// PORTS
// - clock         in   1           system clock
// - reset         in   1           asynchronous, active-low reset
// - I_Req         in   1           thread ready; pushes {I_ThreadID,I_Base,I_Length}
// - I_ThreadID    in   WIDTH_ID    thread ID of pushed entry
// - I_Base        in   WIDTH_ADDR  first instruction address
// - I_Length      in   WIDTH_ADDR  instruction count (0 = empty thread)
// - O_Full        out  1           queue holds NUM_PEND entries
// - O_Req_Ld      out  1           load request to thread memory
// - O_Address_Ld  out  WIDTH_ADDR  load address
// - I_Valid_Ld    in   1           instruction returned (1 cycle after O_Req_Ld)
// - I_Stall       in   1           dispatch stall; suppresses issue
// - O_Start       out  1           1-cycle pulse: new thread begins
// - O_End         out  1           1-cycle pulse: all instructions of thread returned
// - O_ThreadID    out  WIDTH_ID    ID of thread in service (held until next O_Start)
// - O_Busy        out  1           FSM not IDLE
// - O_Error       out  1           sticky: overflow push or unexpected I_Valid_Ld
// BEHAVIOUR
// - Reset (reset==0, async): FSM=IDLE, queue empty, counters 0. All outputs 0.
// - Queue:
//   - Push when I_Req & ~O_Full.
//   - I_Req while O_Full: entry dropped, O_Error<=1.
//   - Full is evaluated before a same-cycle pop, so a push at full is dropped even when popping.
//   - Push and pop in the same non-full cycle are both performed.
//   - Pointers wrap mod NUM_PEND.
// - FSM: IDLE, ISSUE, DRAIN, DONE.
//   - IDLE -> queue non-empty: pop, latch ID/base/length, O_Start=1 next cycle, O_ThreadID updated.
//     - Length!=0 -> ISSUE; length==0 -> DONE.
//   - ISSUE:
//     - O_Req_Ld = ~I_Stall (combinational), O_Address_Ld = R_Addr.
//     - On issue: R_Addr+1 (wraps mod 2^WIDTH_ADDR), R_Remain-1, R_Outst+1.
//     - When the issue sets R_Remain to 0 -> DRAIN.
//   - DRAIN: no issue. Once R_Outst==0 -> DONE.
//   - DONE: O_End=1 for exactly 1 cycle -> IDLE. Next thread's O_Start comes no earlier than 1 cycle later.
// - Outstanding counter (width WIDTH_ADDR+1):
//   - +1 per issue, -1 per I_Valid_Ld; both in one cycle -> unchanged.
//   - I_Valid_Ld with R_Outst==0 and no issue in the previous cycle: ignored, O_Error<=1.
// - Throughput: 1 load/cycle when unstalled. Thread of length L takes L+3 cycles from pop to O_End.
// - I_Stall only blocks issue; returns still count during a stall.
// - O_Error clears only on reset.
// - Async reset mid-thread aborts it; queued entries are lost.
// TESTING
// - Push {ID=5,base=0x010,len=3}, no stall -> O_Start; O_Req_Ld for 3 cycles at 0x010,0x011,0x012.
//   O_End 3 cycles after the last issue; O_ThreadID=5.
// - Same thread, I_Stall=1 on 2nd issue cycle for 2 cycles -> addresses 0x010, 0x011 (held), 0x012.
//   No duplicated or skipped address; O_End delayed 2 cycles.
// - Push len=0 -> O_Start, O_End with zero O_Req_Ld; O_Error stays 0.
// - Push 5 threads back-to-back with the FSM busy and NUM_PEND=4 -> O_Full after the 4th push.
//   5th dropped, O_Error=1; the 4 stored threads run in push order.
// - base=0x3FE, len=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
// - Reset asserted in ISSUE after 2 of 6 loads -> all outputs 0 immediately.
//   Idle after release; a new push runs normally.

Source files
------------

// File: rtl/mpu_thread_fetch_sched_if.sv
// mpu_thread_fetch_sched_if: thread-ready queue, load port and dispatch signals of the fetch scheduler
interface mpu_thread_fetch_sched_if #(
    parameter int WIDTH_ADDR = 10,
    parameter int WIDTH_ID   = 8
);
    logic                  I_Req;
    logic [WIDTH_ID-1:0]   I_ThreadID;
    logic [WIDTH_ADDR-1:0] I_Base;
    logic [WIDTH_ADDR-1:0] I_Length;
    logic                  O_Full;
    logic                  O_Req_Ld;
    logic [WIDTH_ADDR-1:0] O_Address_Ld;
    logic                  I_Valid_Ld;
    logic                  I_Stall;
    logic                  O_Start;
    logic                  O_End;
    logic [WIDTH_ID-1:0]   O_ThreadID;
    logic                  O_Busy;
    logic                  O_Error;
    modport master (
        output I_Req, I_ThreadID, I_Base, I_Length, I_Valid_Ld, I_Stall,
        input  O_Full, O_Req_Ld, O_Address_Ld, O_Start, O_End, O_ThreadID, O_Busy, O_Error
    );
    modport slave (
        input  I_Req, I_ThreadID, I_Base, I_Length, I_Valid_Ld, I_Stall,
        output O_Full, O_Req_Ld, O_Address_Ld, O_Start, O_End, O_ThreadID, O_Busy, O_Error
    );
endinterface

// File: rtl/mpu_thread_fetch_sched.sv
// mpu_thread_fetch_sched: queues ready threads and streams their instruction loads, one per cycle,
// tracking returned beats and flagging thread start/end to dispatch.
module mpu_thread_fetch_sched #(
    parameter int NUM_PEND   = 4,
    parameter int WIDTH_ADDR = 10,
    parameter int WIDTH_ID   = 8
) (
    input logic clock,
    input logic reset,
    mpu_thread_fetch_sched_if.slave bus
);
    localparam int PW = $clog2(NUM_PEND);
    localparam int EW = WIDTH_ID + 2 * WIDTH_ADDR;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t                state, state_nxt;
    logic [EW-1:0]         q_mem [NUM_PEND];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           q_cnt;
    logic [WIDTH_ID-1:0]   h_id, r_id;
    logic [WIDTH_ADDR-1:0] h_base, h_len, r_addr, r_remain;
    logic [WIDTH_ADDR:0]   r_outst;
    logic                  full, push, pop, issue, ret, r_start, r_err;
    assign {h_id, h_base, h_len} = q_mem[rd_ptr];
    assign full  = q_cnt == (PW+1)'(NUM_PEND);
    assign push  = bus.I_Req && !full;
    assign pop   = state == IDLE && q_cnt != '0;
    assign issue = state == ISSUE && !bus.I_Stall;
    // a return with nothing outstanding is spurious and must not underflow the counter
    assign ret   = bus.I_Valid_Ld && r_outst != '0;
    always_ff @(posedge clock) begin
        if (push) q_mem[wr_ptr] <= {bus.I_ThreadID, bus.I_Base, bus.I_Length};
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (q_cnt != '0) state_nxt = h_len != '0 ? ISSUE : DONE;
            ISSUE:   if (issue && r_remain == WIDTH_ADDR'(1)) state_nxt = DRAIN;
            DRAIN:   if (r_outst == '0) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            q_cnt    <= '0;
            r_id     <= '0;
            r_addr   <= '0;
            r_remain <= '0;
            r_outst  <= '0;
            r_start  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            q_cnt   <= q_cnt + (PW+1)'(push) - (PW+1)'(pop);
            r_start <= pop;
            if (pop) begin
                r_id     <= h_id;
                r_addr   <= h_base;
                r_remain <= h_len;
            end else if (issue) begin
                r_addr   <= r_addr + WIDTH_ADDR'(1);
                r_remain <= r_remain - WIDTH_ADDR'(1);
            end
            r_outst <= r_outst + (WIDTH_ADDR+1)'(issue) - (WIDTH_ADDR+1)'(ret);
            r_err   <= r_err || (bus.I_Req && full) || (bus.I_Valid_Ld && r_outst == '0);
        end
    end
    assign bus.O_Full       = full;
    assign bus.O_Req_Ld     = issue;
    assign bus.O_Address_Ld = r_addr;
    assign bus.O_Start      = r_start;
    assign bus.O_End        = state == DONE;
    assign bus.O_ThreadID   = r_id;
    assign bus.O_Busy       = state != IDLE;
    assign bus.O_Error      = r_err;
endmodule
